// File: rtl/quad_loader_pkg.sv
// quad_loader_pkg
//   Shared definitions for the four-sample loader and the min/max stage it
//   feeds: loader state encoding, frame length, default sample width and
//   hold length, and the width rule for the hold counter.
package quad_loader_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_t;

  localparam int FRAME_LEN           = 4;
  localparam int DEFAULT_WIDTH       = 2;
  localparam int DEFAULT_HOLD_CYCLES = 2;

  // The hold counter must be able to represent HOLD_CYCLES itself.
  // It never shrinks below one bit, even when holding is disabled.
  function automatic int hold_cnt_width(input int hold_cycles);
    if (hold_cycles < 1) return 1;
    return $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/quad_sample_loader.sv
// quad_sample_loader
//   Collects a serial stream of WIDTH-bit samples over a valid/ready
//   handshake into four-sample frames. It presents each completed frame on
//   a..d as a single atomic update. After each commit it stalls the input
//   for HOLD_CYCLES cycles, which gives the downstream min/max pipeline time
//   to settle on the frame.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-low
//   clear        in   synchronous flush of the partial frame and outputs
//   in_data      in   WIDTH-bit sample
//   in_valid     in   sample present
//   in_ready     out  loader can accept (decoded from state only)
//   a, b, c, d   out  committed frame, 1st..4th sample in arrival order
//   frame_valid  out  sticky: a frame has been committed since reset/clear
//   frame_strobe out  one-cycle pulse when a new frame lands on a..d
//   fill_count   out  samples currently held in the partial frame (0..3)
module quad_sample_loader
  import quad_loader_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
  output logic             frame_strobe,
  output logic [2:0]       fill_count
);

  localparam int             HCW       = hold_cnt_width(HOLD_CYCLES);
  localparam logic [HCW-1:0] HOLD_INIT = HCW'(HOLD_CYCLES);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(1);
  localparam logic [2:0]     LAST_SLOT = 3'(FRAME_LEN - 1);

  loader_state_t  state;
  loader_state_t  state_next;
  logic [HCW-1:0] hold_cnt;
  logic [HCW-1:0] hold_cnt_next;
  logic [2:0]     fill_next;
  logic           transfer;
  logic           commit;

  // Shadow slots for the first three samples of a frame. The fourth sample
  // goes straight from in_data to d on the commit edge, so it has no slot.
  logic [WIDTH-1:0] s0;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // State, hold counter and fill position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FILL;
      hold_cnt   <= '0;
      fill_count <= '0;
    end else begin
      state      <= state_next;
      hold_cnt   <= hold_cnt_next;
      fill_count <= fill_next;
    end
  end

  // Next-state and handshake decode. in_ready comes from the state alone so
  // that the source never sees a combinational path from in_valid.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    fill_next     = fill_count;
    in_ready      = 1'b0;
    transfer      = 1'b0;
    commit        = 1'b0;

    case (state)
      FILL: begin
        in_ready = 1'b1;
        transfer = in_valid;
        if (transfer) begin
          if (fill_count == LAST_SLOT) begin
            commit    = 1'b1;
            fill_next = '0;
            // A zero-length hold keeps the loader in FILL, which allows
            // back-to-back frames every FRAME_LEN cycles.
            if (HOLD_CYCLES != 0) begin
              state_next    = HOLD;
              hold_cnt_next = HOLD_INIT;
            end
          end else begin
            fill_next = fill_count + 3'd1;
          end
        end
      end

      HOLD: begin
        // The count is checked before it is decremented, so the loader
        // leaves HOLD on the edge where the count reads 1. As a result,
        // in_ready is low for exactly HOLD_CYCLES cycles.
        if (hold_cnt == HOLD_LAST) begin
          state_next    = FILL;
          hold_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt - HCW'(1);
        end
      end

      default: begin
        state_next    = FILL;
        hold_cnt_next = '0;
        fill_next     = '0;
      end
    endcase

    // clear wins over everything, including a transfer in the same cycle.
    // That sample is dropped even though in_ready was high.
    if (clear) begin
      state_next    = FILL;
      hold_cnt_next = '0;
      fill_next     = '0;
      transfer      = 1'b0;
      commit        = 1'b0;
    end
  end

  // Partial-frame capture. Slots are never read before they are rewritten
  // after a clear, so clear does not need to touch them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
    end else if (transfer && !commit) begin
      case (fill_count)
        3'd0:    s0 <= in_data;
        3'd1:    s1 <= in_data;
        3'd2:    s2 <= in_data;
        default: ;
      endcase
    end
  end

  // Committed frame. All four outputs load on the same edge, which keeps
  // the downstream stage from ever seeing a mix of two frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a            <= '0;
      b            <= '0;
      c            <= '0;
      d            <= '0;
      frame_valid  <= 1'b0;
      frame_strobe <= 1'b0;
    end else if (clear) begin
      a            <= '0;
      b            <= '0;
      c            <= '0;
      d            <= '0;
      frame_valid  <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= commit;
      if (commit) begin
        a           <= s0;
        b           <= s1;
        c           <= s2;
        d           <= in_data;
        frame_valid <= 1'b1;
      end
    end
  end

  // Structural invariants of the loader.
  a_fill_range : assert property (@(posedge clk) disable iff (!rst)
    fill_count <= LAST_SLOT);

  a_strobe_valid : assert property (@(posedge clk) disable iff (!rst)
    frame_strobe |-> frame_valid);

  a_hold_nonzero : assert property (@(posedge clk) disable iff (!rst)
    (state == HOLD) |-> (hold_cnt != '0));

  // With a hold in place, two commits can never be on adjacent edges.
  if (HOLD_CYCLES > 0) begin : g_strobe_single
    a_strobe_pulse : assert property (@(posedge clk) disable iff (!rst)
      frame_strobe |=> !frame_strobe);
  end

endmodule

// File: tb/tb_quad_sample_loader.sv
// tb_quad_sample_loader
//   Scoreboard bench for quad_sample_loader. Two instances share the clock
//   and reset: dut (HOLD_CYCLES = 2) and dut_z (HOLD_CYCLES = 0). Stimulus
//   pushes each expected frame into a per-instance queue. A monitor per
//   instance pops the queue and compares whenever frame_strobe is seen.
module tb_quad_sample_loader;
  import quad_loader_pkg::*;

  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         clear;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, c, d;
  logic         frame_valid;
  logic         frame_strobe;
  logic [2:0]   fill_count;

  logic         clear_z;
  logic [W-1:0] in_data_z;
  logic         in_valid_z;
  logic         in_ready_z;
  logic [W-1:0] a_z, b_z, c_z, d_z;
  logic         frame_valid_z;
  logic         frame_strobe_z;
  logic [2:0]   fill_count_z;

  quad_sample_loader #(.WIDTH(W), .HOLD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d),
    .frame_valid(frame_valid), .frame_strobe(frame_strobe),
    .fill_count(fill_count)
  );

  quad_sample_loader #(.WIDTH(W), .HOLD_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst), .clear(clear_z), .in_data(in_data_z),
    .in_valid(in_valid_z), .in_ready(in_ready_z), .a(a_z), .b(b_z),
    .c(c_z), .d(d_z), .frame_valid(frame_valid_z),
    .frame_strobe(frame_strobe_z), .fill_count(fill_count_z)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [4*W-1:0] exp_q[$];
  logic [4*W-1:0] exp_q_z[$];
  int             strobe_cyc_z[$];

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Drive one sample, called at a negedge. in_valid is held until the loader
  // shows in_ready, so the transfer happens on the following posedge. The
  // task returns at the negedge after that posedge, with in_valid still high
  // for a continuous stream. acc_cyc records the cycle of acceptance.
  task automatic applyStimulus(input bit sel, input logic [W-1:0] data,
                               output int acc_cyc);
    int waited;
    waited = 0;
    if (sel) begin
      in_data_z  = data;
      in_valid_z = 1'b1;
    end else begin
      in_data  = data;
      in_valid = 1'b1;
    end
    while (!(sel ? in_ready_z : in_ready)) begin
      if (waited == 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout actual=not_ready required=ready");
        acc_cyc = -1;
        return;
      end
      waited++;
      @(negedge clk);
    end
    acc_cyc = cyc;
    @(negedge clk);
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (rst && frame_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_frame actual=%0h required=none", {a, b, c, d});
      end else begin
        checkOutput("frame", {24'd0, a, b, c, d}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rst && frame_strobe_z === 1'b1) begin
      strobe_cyc_z.push_back(cyc);
      if (exp_q_z.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_frame_z actual=%0h required=none",
                 {a_z, b_z, c_z, d_z});
      end else begin
        checkOutput("frame_z", {24'd0, a_z, b_z, c_z, d_z}, {24'd0, exp_q_z.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [W-1:0] s1_dat [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
  logic [W-1:0] s2_dat [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
  bit           tg_val [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int           tg_fill[7] = '{1, 1, 1, 2, 3, 3, 0};
  logic [W-1:0] tg_dat [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
  logic [W-1:0] cl_dat [4] = '{2'd0, 2'd3, 2'd1, 2'd2};
  logic [W-1:0] rh_dat [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
  logic [W-1:0] hz_dat [8] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd2, 2'd1, 2'd3};

  initial begin
    int acc [8];
    int di;
    rst        = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    clear_z    = 1'b0;
    in_valid_z = 1'b0;
    in_data_z  = '0;
    repeat (2) @(negedge clk);

    // Reset state.
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_abcd", {24'd0, a, b, c, d}, 32'd0);
    checkOutput("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    checkOutput("rst_strobe", {31'd0, frame_strobe}, 32'd0);
    checkOutput("rst_fill", {29'd0, fill_count}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // First frame 3,1,2,0, followed by the two-cycle hold.
    exp_q.push_back({2'd3, 2'd1, 2'd2, 2'd0});
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, s1_dat[i], acc[i]);
      checkOutput("t1_fill", {29'd0, fill_count}, (i + 1) % 4);
    end
    in_valid = 1'b0;
    checkOutput("t1_frame_valid", {31'd0, frame_valid}, 32'd1);
    checkOutput("t1_ready_hold0", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    checkOutput("t1_ready_hold1", {31'd0, in_ready}, 32'd0);
    checkOutput("t1_strobe_pulse", {31'd0, frame_strobe}, 32'd0);
    checkOutput("t1_abcd_held1", {24'd0, a, b, c, d}, {24'd0, 2'd3, 2'd1, 2'd2, 2'd0});
    @(negedge clk);
    checkOutput("t1_ready_back", {31'd0, in_ready}, 32'd1);
    checkOutput("t1_abcd_held2", {24'd0, a, b, c, d}, {24'd0, 2'd3, 2'd1, 2'd2, 2'd0});

    // Eight-sample continuous stream: the fifth sample waits out the hold.
    exp_q.push_back({2'd0, 2'd1, 2'd2, 2'd3});
    exp_q.push_back({2'd3, 2'd2, 2'd1, 2'd0});
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, s2_dat[i], acc[i]);
    in_valid = 1'b0;
    checkOutput("t2_fill_gap", acc[3] - acc[0], 32'd3);
    checkOutput("t2_hold_gap", acc[4] - acc[3], 32'd3);
    checkOutput("t2_second_gap", acc[7] - acc[4], 32'd3);
    repeat (2) @(negedge clk);

    // Gaps in in_valid stretch the fill without losing position.
    exp_q.push_back({2'd2, 2'd3, 2'd0, 2'd1});
    di = 0;
    for (int k = 0; k < 7; k++) begin
      in_valid = tg_val[k];
      if (tg_val[k]) begin
        in_data = tg_dat[di];
        di++;
      end
      @(negedge clk);
      checkOutput("t3_fill", {29'd0, fill_count}, tg_fill[k]);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // clear together with in_valid after two accepted samples.
    applyStimulus(1'b0, 2'd1, acc[0]);
    applyStimulus(1'b0, 2'd2, acc[1]);
    checkOutput("t4_fill_before", {29'd0, fill_count}, 32'd2);
    in_data = 2'd3;
    clear   = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    checkOutput("t4_fill", {29'd0, fill_count}, 32'd0);
    checkOutput("t4_abcd", {24'd0, a, b, c, d}, 32'd0);
    checkOutput("t4_frame_valid", {31'd0, frame_valid}, 32'd0);
    checkOutput("t4_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back({2'd0, 2'd3, 2'd1, 2'd2});
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, cl_dat[i], acc[i]);
    in_valid = 1'b0;
    checkOutput("t4_frame_valid_after", {31'd0, frame_valid}, 32'd1);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of the hold.
    exp_q.push_back({2'd1, 2'd2, 2'd3, 2'd3});
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, rh_dat[i], acc[i]);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t5_in_hold", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("t5_ready_async", {31'd0, in_ready}, 32'd1);
    checkOutput("t5_abcd_async", {24'd0, a, b, c, d}, 32'd0);
    checkOutput("t5_frame_valid_async", {31'd0, frame_valid}, 32'd0);
    checkOutput("t5_fill_async", {29'd0, fill_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("t5_no_stale_valid", {31'd0, frame_valid}, 32'd0);
    checkOutput("t5_no_stale_fill", {29'd0, fill_count}, 32'd0);

    // Zero-length hold: back-to-back frames every four cycles.
    exp_q_z.push_back({2'd1, 2'd3, 2'd0, 2'd2});
    exp_q_z.push_back({2'd2, 2'd2, 2'd1, 2'd3});
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, hz_dat[i], acc[i]);
    checkOutput("t6_ready", {31'd0, in_ready_z}, 32'd1);
    in_valid_z = 1'b0;
    checkOutput("t6_no_stall", acc[7] - acc[0], 32'd7);
    @(negedge clk);
    checkOutput("t6_strobe_count", strobe_cyc_z.size(), 32'd2);
    if (strobe_cyc_z.size() == 2)
      checkOutput("t6_strobe_period", strobe_cyc_z[1] - strobe_cyc_z[0], 32'd4);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size() + exp_q_z.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
